// File: rtl/serial_ctrl_pkg.sv
// ============================================================================
// Module   : serial_ctrl_pkg
// Brief    : Shared state encoding and defaults for the serial shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_ctrl_pkg;

    localparam int c_state_w       = 2;
    localparam int c_default_width = 8;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_shift_reg.sv
// ============================================================================
// Module   : serial_shift_reg
// Brief    : Loadable bidirectional shift register; reports the head bit the
//            register will present after this edge, and the word's parity
//            (parity port present only with SERIAL_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shift_reg
    import serial_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    input  logic             i_lsb_first,
    output logic             o_head_next
`ifdef SERIAL_PARITY_EN
    ,
    output logic             o_parity
`endif
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= i_lsb_first ? {1'b0, r_data[WIDTH-1:1]}
                                  : {r_data[WIDTH-2:0], 1'b0};
        end
    end

    // Look-ahead head bit lets the controller register sout in step with the data.
    always_comb begin
        o_head_next = i_lsb_first ? r_data[0] : r_data[WIDTH-1];
        if (i_load) begin
            o_head_next = i_lsb_first ? i_data[0] : i_data[WIDTH-1];
        end else if (i_shift) begin
            o_head_next = i_lsb_first ? r_data[1] : r_data[WIDTH-2];
        end
    end

`ifdef SERIAL_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_parity <= ^i_data;
        end
    end

    assign o_parity = r_parity;
`endif

endmodule

`default_nettype wire

// File: rtl/serial_shift_ctrl.sv
// ============================================================================
// Module   : serial_shift_ctrl
// Brief    : Parallel-in / serial-out frame sequencer with valid/ready load,
//            shift_en rate control and a one-cycle done pulse.
//            Optional trailing even-parity bit: define SERIAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shift_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_load;
    logic               w_at_last;
    logic               w_shift;
    logic               w_frame_end;
    logic               w_head_next;
    logic               w_parity;
    logic               w_sout_next;
    logic               w_active_next;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_busy;
    logic               r_done;

    assign w_load    = (r_state == ST_IDLE) && load_valid;
    assign w_at_last = (r_cnt == c_last);
    assign w_shift   = (r_state == ST_SHIFT) && shift_en && !w_at_last;

    serial_shift_reg #(
        .WIDTH       (WIDTH)
    ) u_shift_reg (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_load),
        .i_data      (load_data),
        .i_shift     (w_shift),
        .i_lsb_first (LSB_FIRST),
        .o_head_next (w_head_next)
`ifdef SERIAL_PARITY_EN
        ,
        .o_parity    (w_parity)
`endif
    );

`ifndef SERIAL_PARITY_EN
    assign w_parity = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_en && w_at_last) begin
`ifdef SERIAL_PARITY_EN
                    w_state_next = ST_PAR;
`else
                    w_state_next = ST_IDLE;
                    w_frame_end  = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PAR: begin
                if (shift_en) begin
                    w_state_next = ST_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear in the cycle the state does.
    always_comb begin
        w_active_next = (w_state_next != ST_IDLE);
        w_sout_next   = 1'b0;
        if (w_state_next == ST_SHIFT) begin
            w_sout_next = w_head_next;
        end else if (w_state_next == ST_PAR) begin
            w_sout_next = w_parity;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sout       <= w_sout_next;
            r_sout_valid <= w_active_next;
            r_busy       <= w_active_next;
            r_done       <= w_frame_end;
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_shift_ctrl.sv
// ============================================================================
// Module   : tb_serial_shift_ctrl
// Brief    : Self-checking bench for serial_shift_ctrl (LSB- and MSB-first
//            instances); honours SERIAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_shift_ctrl;

`ifdef SERIAL_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [1:0] load_ready_w, sout_w, sout_valid_w, busy_w, done_w;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_w[0]), .shift_en(shift_en), .sout(sout_w[0]),
        .sout_valid(sout_valid_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    serial_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_w[1]), .shift_en(shift_en), .sout(sout_w[1]),
        .sout_valid(sout_valid_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: list of bits to emit, index of the bit on the wire.
    function automatic logic [8:0] build(input logic [7:0] d, input bit lsb);
        logic [8:0] b;
        for (int k = 0; k < 8; k++) b[k] = lsb ? d[k] : d[7-k];
        b[8] = ^d;
        return b;
    endfunction

    bit         m_act  [2];
    int         m_idx  [2];
    logic [8:0] m_bits [2];
    bit         m_done [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (!m_act[i]) begin
                    if (load_valid) begin
                        m_bits[i] = build(load_data, i == 0);
                        m_idx[i]  = 0;
                        m_act[i]  = 1'b1;
                    end
                end else if (shift_en) begin
                    if (m_idx[i] == F - 1) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_idx[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "L sout" : "M sout", sout_w[i],
                    m_act[i] ? m_bits[i][m_idx[i]] : 1'b0);
                chk(i == 0 ? "L sout_valid" : "M sout_valid", sout_valid_w[i], m_act[i]);
                chk(i == 0 ? "L busy" : "M busy", busy_w[i], m_act[i]);
                chk(i == 0 ? "L done" : "M done", done_w[i], m_done[i]);
                chk(i == 0 ? "L load_ready" : "M load_ready", load_ready_w[i], !m_act[i]);
            end
        end
    end

    logic [8:0] sl, sm;
    int         early, rdy_hi, done_at, vcnt, nd;
    logic       dn, dn2;

    // Loads d with shift_en held high; DUT must be idle on entry.
    task automatic run_frame(input logic [7:0] d);
        load_valid = 1'b1; load_data = d; shift_en = 1'b1;
        @(posedge clk); #1; load_valid = 1'b0;
        sl = '0; sm = '0; early = 0; rdy_hi = 0;
        for (int k = 0; k < F; k++) begin
            @(negedge clk);
            sl[k] = sout_w[0];
            sm[k] = sout_w[1];
            if (done_w != 2'b00) early++;
            if (load_ready_w != 2'b00) rdy_hi++;
        end
        @(negedge clk); dn = done_w[0] & done_w[1];
        @(negedge clk); dn2 = done_w[0] | done_w[1];
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1; chk_en = 1'b1;
        @(negedge clk);
        chk("reset sout", sout_w, 2'b00);
        chk("reset sout_valid", sout_valid_w, 2'b00);
        chk("reset busy", busy_w, 2'b00);
        chk("reset done", done_w, 2'b00);
        chk("reset load_ready", load_ready_w, 2'b11);
        reset = 1'b0;

        run_frame(8'hA5);
        chk("A5 lsb bits", sl[7:0], 8'hA5);
        chk("A5 msb bits", sm[7:0], 8'hA5);
        chk("A5 early done", early, 0);
        chk("A5 done pulse", dn, 1'b1);
        chk("A5 done width", dn2, 1'b0);

        run_frame(8'h81);
        chk("81 msb bits", sm[7:0], 8'h81);
        chk("81 ready low in frame", rdy_hi, 0);

`ifdef SERIAL_PARITY_EN
        run_frame(8'h07);
        chk("07 parity bit", sl[8], 1'b1);
        chk("07 done after parity", dn, 1'b1);
        run_frame(8'h03);
        chk("03 parity bit", sl[8], 1'b0);
`endif

        // Rate control: one shift_en every third cycle.
        load_valid = 1'b1; load_data = 8'hFF; shift_en = 1'b0;
        @(posedge clk); #1; load_valid = 1'b0;
        done_at = -1; vcnt = 0;
        for (int j = 0; j < 40; j++) begin
            shift_en = (j % 3 == 2);
            @(negedge clk);
            if (done_w[0] && done_at < 0) done_at = j;
            if (done_at < 0 && sout_valid_w[0]) vcnt++;
            @(posedge clk); #1;
        end
        chk("rate done latency", done_at, 3 * F);
        chk("rate valid continuous", vcnt, 3 * F);

        // Abort after the 4th bit.
        load_valid = 1'b1; load_data = 8'h5A; shift_en = 1'b1;
        @(posedge clk); #1; load_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("abort sout", sout_w, 2'b00);
        chk("abort sout_valid", sout_valid_w, 2'b00);
        chk("abort busy", busy_w, 2'b00);
        chk("abort done", done_w, 2'b00);
        chk("abort load_ready", load_ready_w, 2'b11);
        nd = 0;
        repeat (12) begin @(negedge clk); if (done_w != 2'b00) nd++; end
        chk("abort no done", nd, 0);

        // Back-to-back with load_valid held through the frame.
        @(posedge clk); #1;
        load_valid = 1'b1; load_data = 8'h3C; shift_en = 1'b1;
        @(posedge clk); #1; load_data = 8'hC3;
        rdy_hi = 0;
        for (int k = 0; k < F; k++) begin
            @(negedge clk);
            if (load_ready_w != 2'b00) rdy_hi++;
        end
        chk("b2b ready low mid-frame", rdy_hi, 0);
        @(negedge clk);
        chk("b2b done", done_w, 2'b11);
        chk("b2b ready in done cycle", load_ready_w, 2'b11);
        @(posedge clk); #1; load_valid = 1'b0;
        @(negedge clk);
        chk("b2b second busy", busy_w, 2'b11);
        chk("b2b second first bit", sout_w, 2'b11);
        repeat (F + 3) begin @(posedge clk); #1; end

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 63) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = 8'($urandom);
            shift_en   = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        reset = 1'b0; load_valid = 1'b0; shift_en = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
